spi_slave: RTL
==============

// Module: spi_slave
// PURPOSE
//  SPI target (slave) end of the team SPI link, clocked by the local system clock.
//  Oversamples sclk/ss_n/mosi through synchronizers and shifts full-duplex words, MSB first.
//  Presents each received word with a one-cycle strobe and takes transmit words via valid/ready.
//  Sits opposite the SPI master on the board-level bus; one instance per chip-select line.
// PARAMETERS
//  SPI_MODE    2'd0  SPI mode 0..3 (bit1 = CPOL, bit0 = CPHA); must match the master.
//  DATA_WIDTH  8     Bits per word; must be >= 2.
//  SYNC_STAGES 2     Synchronizer depth on sclk, ss_n and mosi; must be >= 2.
// PORTS
//  clk         in   1           System clock; frequency >= 4x SPI sclk.
//  rst_n       in   1           Asynchronous, active-low reset.
//  sclk        in   1           SPI clock from the master (asynchronous to clk).
//  ss_n        in   1           Active-low select (asynchronous to clk).
//  mosi        in   1           Master-out serial data.
//  miso        out  1           Slave-out serial data, MSB first.
//  miso_oe     out  1           Output enable for the miso pad driver; high only while selected.
//  tx_data     in   DATA_WIDTH  Word to transmit next.
//  tx_valid    in   1           tx_data valid.
//  tx_ready    out  1           Transmit holding buffer empty; transfer on tx_valid & tx_ready.
//  rx_data     out  DATA_WIDTH  Last complete received word; held until the next word completes.
//  rx_valid    out  1           One-clk strobe: rx_data updated.
//  busy        out  1           High while the synchronized ss_n is low.
//  tx_underrun out  1           One-clk strobe: a word load found the holding buffer empty.
// BEHAVIOUR
//  - Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, tx_underrun=0.
//    Holding buffer is emptied, state is IDLE, and the bit counter is 0.
//  - Edge detect: compare the last synchronizer stage with a registered copy.
//    sample_edge is rising for modes 0 and 3, falling for modes 1 and 2.
//    shift_edge is the opposite edge.
//  - FSM IDLE -> ACTIVE on the synchronized ss_n falling edge.
//    ACTIVE -> IDLE on the synchronized ss_n rising edge.
//  - Word load, at ss_n fall and after each completed word while ss_n stays low:
//    * If the buffer is full, its word goes to tx_shift and the buffer empties (tx_ready=1 the next cycle).
//    * If the buffer is empty, tx_shift is loaded with all zeros and tx_underrun pulses.
//  - miso = tx_shift[MSB]; miso_oe = busy.
//    CPHA=0: the MSB is on miso before the first sample edge; tx_shift shifts left on each shift_edge,
//    except a shift_edge that completes a word reloads instead.
//    CPHA=1: the first shift_edge after select does not shift, so the MSB appears there;
//    tx_shift then shifts left on each later shift_edge.
//  - On each sample_edge in ACTIVE: rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_sync}, and bit_cnt increments.
//  - When bit_cnt reaches DATA_WIDTH-1 at a sample_edge:
//    * rx_data <= the completed word and rx_valid=1 on the next clk. Latency is SYNC_STAGES+1 clk after the pin edge.
//    * bit_cnt wraps to 0 and the next word load is armed.
//  - rx has no backpressure: the consumer must take rx_data within one word time or it is overwritten.
//  - A tx handshake in the same cycle as a word load: the load uses the old buffer state.
//    The new word is then accepted into the now-empty buffer, so no word is lost.
//  - ss_n deasserted mid-word: the partial rx word is discarded with no rx_valid, and bit_cnt returns to 0.
//    miso_oe drops in the same cycle as busy. The holding buffer is kept.
//  - sclk edges while ss_n is high are ignored.
//  - rst_n asserted mid-transfer: all state returns immediately to the reset values.
// STRUCTURE
//  - spi_pkg holds:
//    * typedef logic [1:0] spi_mode_t;
//    * functions cpol(mode) and cpha(mode);
//    * localparams SPI_MODE0..SPI_MODE3.
//    The master shares this package.
//  - Sub-module spi_sync: a SYNC_STAGES-deep flop synchronizer, instantiated for sclk, ss_n and mosi.
//  - Body: edge detect, a 2-state FSM, bit counter, tx/rx shift registers, and the tx holding buffer.
// TESTING
//  1. Mode 0, 8-bit. Preload tx 0xA5; master sends 0x3C -> miso shows 0xA5 MSB first;
//     rx_data=0x3C with a single rx_valid pulse.
//  2. Modes 1, 2 and 3 repeated with tx 0x81 / mosi 0x7E -> both words are correct in every mode,
//     and CPHA=1 timing is verified.
//  3. Burst: 3 words with ss_n held low; tx 0x11, 0x22 written after each rx_valid ->
//     rx matches master 0xDE, 0xAD, 0xBE; miso gives 0x11, 0x22, and the third word is 0x00 with a tx_underrun pulse.
//  4. ss_n raised after 5 bits -> no rx_valid; busy=0 and miso_oe=0.
//     The next full transfer of 0x55 receives correctly.
//  5. rst_n pulsed mid-word -> all outputs at reset values; tx_ready=1; a subsequent transfer is clean.
//  6. sclk toggling with ss_n high, and a tx write in the load cycle -> rx_valid stays 0; the written word is not lost.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both ends of the team SPI link.
// Mode encoding is {CPOL, CPHA}.
package spi_pkg;

  typedef logic [1:0] spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = 2'd0;
  localparam spi_mode_t SPI_MODE1 = 2'd1;
  localparam spi_mode_t SPI_MODE2 = 2'd2;
  localparam spi_mode_t SPI_MODE3 = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  function automatic logic cpol(input spi_mode_t mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input spi_mode_t mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input.
// Resets to RST_VAL so the idle level does not look like an edge.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI target clocked by the system clock: oversampled sclk/ss_n/mosi,
// full-duplex MSB-first words, valid/ready transmit holding buffer.
module spi_slave
  import spi_pkg::*;
#(
  parameter spi_mode_t SPI_MODE    = SPI_MODE0,
  parameter int        DATA_WIDTH  = 8,
  parameter int        SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun
);

  localparam logic CPOL  = cpol(SPI_MODE);
  localparam logic CPHA  = cpha(SPI_MODE);
  localparam int   CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_s, ss_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_i(sclk), .sync_o(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .async_i(ss_n), .sync_o(ss_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .async_i(mosi), .sync_o(mosi_s)
  );

  spi_state_e state_q, state_d;
  logic                  sclk_prev_q, ss_prev_q;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic                  armed_q, armed_d;
  logic                  skip_q, skip_d;

  logic sclk_rise, sclk_fall, sample_edge, shift_edge;
  logic ss_fall, ss_rise, in_xfer;
  logic start_load, next_load, load_now, accept;
  logic [DATA_WIDTH-1:0] rx_word;

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign sample_edge = (CPOL ^ CPHA) ? sclk_fall : sclk_rise;
  assign shift_edge  = (CPOL ^ CPHA) ? sclk_rise : sclk_fall;
  assign ss_fall     = ~ss_s & ss_prev_q;
  assign ss_rise     = ss_s & ~ss_prev_q;
  assign in_xfer     = (state_q == ST_ACTIVE) && !ss_rise;

  // CPHA=0 reloads on the shift edge closing a word; CPHA=1 reloads right after the last sample.
  assign start_load = (state_q == ST_IDLE) && ss_fall;
  assign next_load  = armed_q && in_xfer && (CPHA || shift_edge);
  assign load_now   = start_load || next_load;
  assign accept     = tx_valid && !buf_full_q;
  assign rx_word    = {rx_shift_q, mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (ss_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (ss_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == ST_ACTIVE);
    miso_oe = (state_q == ST_ACTIVE);
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    armed_d    = armed_q;
    skip_d     = skip_q;

    if (!in_xfer) begin
      bit_cnt_d = '0;
      armed_d   = 1'b0;
      skip_d    = 1'b0;
    end

    // A load sees the buffer as it was at the start of the cycle; a same-cycle write refills it.
    if (load_now) begin
      tx_shift_d = buf_full_q ? buf_q : '0;
      underrun_d = !buf_full_q;
      buf_full_d = 1'b0;
      armed_d    = 1'b0;
      skip_d     = CPHA;
    end else if (in_xfer && shift_edge) begin
      if (skip_q) begin
        skip_d = 1'b0;
      end else begin
        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
      end
    end

    if (accept) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    if (in_xfer && sample_edge) begin
      rx_shift_d = rx_word[DATA_WIDTH-2:0];
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d  = '0;
        rx_data_d  = rx_word;
        rx_valid_d = 1'b1;
        armed_d    = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_q <= CPOL;
      ss_prev_q   <= 1'b1;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      armed_q     <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      armed_q     <= armed_d;
      skip_q      <= skip_d;
    end
  end

  assign miso        = tx_shift_q[DATA_WIDTH-1];
  assign tx_ready    = !buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule
